// File: rtl/resp_cap_pkg.sv
// Shared constants and state type for the response MISR capture block.
// Holds bus widths, MISR polynomial/seed defaults and the capture FSM enum.
package resp_cap_pkg;

    localparam int Y_W   = 474;
    localparam int SIG_W = 32;
    localparam int CNT_W = 16;

    localparam logic [SIG_W-1:0] POLY = 32'h04C11DB7;
    localparam logic [SIG_W-1:0] SEED = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/response_misr_capture_y_fold.sv
// y_fold: combinational XOR folder, Y_W-bit bus -> SIG_W-bit word.
// Ports: y_i (response bus), fold_o (XOR of zero-padded SIG_W slices).
module y_fold #(
    parameter int Y_W   = 474,
    parameter int SIG_W = 32
) (
    input  logic [Y_W-1:0]   y_i,
    output logic [SIG_W-1:0] fold_o
);

    localparam int NS = (Y_W + SIG_W - 1) / SIG_W;
    localparam int PW = NS * SIG_W;

    logic [PW-1:0] pad;

    // Zero-extend so the top slice is padded with zeros.
    assign pad = PW'(y_i);

    always_comb begin
        fold_o = '0;
        for (int i = 0; i < NS; i++) begin
            fold_o = fold_o ^ pad[i*SIG_W +: SIG_W];
        end
    end

endmodule

// File: rtl/response_misr_capture.sv
// Response capture: compacts valid y samples into a MISR signature over a
// programmed window. Ports: clk, rst_n, start, abort, num_cycles, y_in,
// y_valid, expected_sig in; busy, done, signature, match, sample_count out.
module response_misr_capture
    import resp_cap_pkg::*;
#(
    parameter int               Y_W   = resp_cap_pkg::Y_W,
    parameter int               SIG_W = resp_cap_pkg::SIG_W,
    parameter int               CNT_W = resp_cap_pkg::CNT_W,
    parameter logic [SIG_W-1:0] POLY  = resp_cap_pkg::POLY,
    parameter logic [SIG_W-1:0] SEED  = resp_cap_pkg::SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_cycles,
    input  logic [Y_W-1:0]   y_in,
    input  logic             y_valid,
    input  logic [SIG_W-1:0] expected_sig,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature,
    output logic             match,
    output logic [CNT_W-1:0] sample_count
);

    state_e           state_q, state_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic             match_q, match_d;

    logic [SIG_W-1:0] fold;
    logic [SIG_W-1:0] sig_step;
    logic [CNT_W-1:0] cnt_inc;

    y_fold #(
        .Y_W   (Y_W),
        .SIG_W (SIG_W)
    ) u_fold (
        .y_i    (y_in),
        .fold_o (fold)
    );

    assign sig_step = {sig_q[SIG_W-2:0], 1'b0}
                    ^ (sig_q[SIG_W-1] ? POLY : '0)
                    ^ fold;
    assign cnt_inc  = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sig_q   <= '0;
            cnt_q   <= '0;
            num_q   <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            match_q <= match_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        match_d = match_q;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    num_d   = num_cycles;
                    sig_d   = SEED;
                    cnt_d   = '0;
                    match_d = 1'b0;
                    state_d = (num_cycles == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (y_valid) begin
                    sig_d = sig_step;
                    cnt_d = cnt_inc;
                    if (cnt_inc == num_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // An abort here cancels the completion, so match keeps 0.
                if (!abort) begin
                    match_d = (sig_q == expected_sig);
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy         = (state_q == RUN);
    assign done         = (state_q == DONE) && !abort;
    assign signature    = sig_q;
    assign match        = match_q;
    assign sample_count = cnt_q;

endmodule

// File: tb/tb_response_misr_capture.sv
// Self-checking bench for response_misr_capture: directed windows plus a
// randomized soak, all compared every cycle against a behavioural model.
module tb_response_misr_capture;

    localparam logic [31:0] P  = 32'h04C11DB7;
    localparam logic [31:0] SD = 32'hFFFFFFFF;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [15:0]  num_cycles;
    logic [473:0] y_in;
    logic         y_valid;
    logic [31:0]  expected_sig;
    logic         busy;
    logic         done;
    logic [31:0]  signature;
    logic         match;
    logic [15:0]  sample_count;

    int n_chk;
    int n_fail;

    // model state: phase 0 = idle, 1 = capturing, 2 = completion cycle
    int          m_ph;
    logic [31:0] m_sig;
    logic [15:0] m_cnt;
    logic [15:0] m_num;
    logic        m_match;

    logic [473:0] vec[32];
    int           ndone;

    response_misr_capture dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .num_cycles   (num_cycles),
        .y_in         (y_in),
        .y_valid      (y_valid),
        .expected_sig (expected_sig),
        .busy         (busy),
        .done         (done),
        .signature    (signature),
        .match        (match),
        .sample_count (sample_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Bit i of the bus lands in signature bit i mod 32.
    function automatic logic [31:0] fold_ref(input logic [473:0] y);
        logic [31:0] f = '0;
        for (int i = 0; i < 474; i++) f[i % 32] = f[i % 32] ^ y[i];
        return f;
    endfunction

    function automatic logic [31:0] misr_ref(input logic [31:0] s,
                                             input logic [473:0] y);
        logic [31:0] n = s << 1;
        if (s[31]) n = n ^ P;
        return n ^ fold_ref(y);
    endfunction

    function automatic logic [31:0] sig_of(input int n);
        logic [31:0] s = SD;
        for (int i = 0; i < n; i++) s = misr_ref(s, vec[i]);
        return s;
    endfunction

    function automatic logic [473:0] rand_y();
        logic [479:0] r;
        for (int i = 0; i < 15; i++) r[i*32 +: 32] = $urandom;
        return r[473:0];
    endfunction

    // Compare at the falling edge, then advance the model with the inputs
    // the DUT will sample at the next rising edge.
    initial begin
        m_ph = 0; m_sig = '0; m_cnt = '0; m_num = '0; m_match = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_ph = 0; m_sig = '0; m_cnt = '0; m_num = '0;
                m_match = 1'b0;
            end
            chk("busy", 64'(busy), 64'(m_ph == 1));
            chk("done", 64'(done), 64'(m_ph == 2 && !abort && rst_n));
            chk("signature", 64'(signature), 64'(m_sig));
            chk("match", 64'(match), 64'(m_match));
            chk("sample_count", 64'(sample_count), 64'(m_cnt));
            if (rst_n) begin
                if (m_ph == 2 && !abort) ndone++;
                case (m_ph)
                    0: if (start && !abort) begin
                        m_num = num_cycles; m_sig = SD; m_cnt = '0;
                        m_match = 1'b0;
                        m_ph = (num_cycles == 0) ? 2 : 1;
                    end
                    1: if (abort) m_ph = 0;
                       else if (y_valid) begin
                        m_sig = misr_ref(m_sig, y_in);
                        m_cnt = m_cnt + 16'd1;
                        if (m_cnt == m_num) m_ph = 2;
                    end
                    default: begin
                        if (!abort) m_match = (m_sig == expected_sig);
                        m_ph = 0;
                    end
                endcase
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_in();
        start = 0; abort = 0; y_valid = 0; y_in = '0;
    endtask

    task automatic begin_win(input logic [15:0] n);
        start = 1; num_cycles = n;
        step();
        start = 0;
    endtask

    logic [31:0] sa;
    int          nd0;

    initial begin
        n_chk = 0; n_fail = 0; ndone = 0;
        rst_n = 0; idle_in(); num_cycles = '0; expected_sig = '0;
        step(); step();
        chk("reset_sig", 64'(signature), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        rst_n = 1;
        step();

        // single zero sample
        expected_sig = 32'hFB3EE249;
        begin_win(16'd1);
        chk("busy_after_start", 64'(busy), 64'h1);
        y_in = '0; y_valid = 1;
        step();
        y_valid = 0;
        chk("t1_done", 64'(done), 64'h1);
        chk("t1_sig", 64'(signature), 64'hFB3EE249);
        chk("t1_busy_in_done", 64'(busy), 64'h0);
        step();
        chk("t1_match", 64'(match), 64'h1);
        chk("t1_done_gone", 64'(done), 64'h0);

        // single sample of value 1, mismatching golden
        expected_sig = 32'h0;
        begin_win(16'd1);
        y_in = 474'h1; y_valid = 1;
        step();
        y_valid = 0;
        chk("t2_sig", 64'(signature), 64'hFB3EE248);
        step();
        chk("t2_match", 64'(match), 64'h0);

        // empty window
        begin_win(16'd0);
        chk("t3_done", 64'(done), 64'h1);
        chk("t3_sig", 64'(signature), 64'hFFFFFFFF);
        chk("t3_cnt", 64'(sample_count), 64'h0);
        step();

        // three samples contiguous, then gapped with a stray start
        for (int i = 0; i < 3; i++) vec[i] = rand_y();
        begin_win(16'd3);
        for (int i = 0; i < 3; i++) begin
            y_in = vec[i]; y_valid = 1; step();
        end
        y_valid = 0;
        chk("t4_contig", 64'(signature), 64'(sig_of(3)));
        sa = signature;
        step();
        begin_win(16'd3);
        begin
            int pat[6] = '{1, 0, 1, 0, 0, 1};
            int k = 0;
            for (int i = 0; i < 6; i++) begin
                y_valid = pat[i][0];
                y_in = pat[i] != 0 ? vec[k] : rand_y();
                start = (i == 3);
                num_cycles = 16'd9;
                if (pat[i] != 0) k++;
                step();
            end
        end
        start = 0; y_valid = 0;
        chk("t4_gapped", 64'(signature), 64'(sig_of(3)));
        chk("t4_same", 64'(signature), 64'(sa));
        step();

        // reset mid-window
        nd0 = ndone;
        begin_win(16'd5);
        for (int i = 0; i < 2; i++) begin
            y_in = rand_y(); y_valid = 1; step();
        end
        rst_n = 0;
        #1;
        chk("t5_rst_busy", 64'(busy), 64'h0);
        chk("t5_rst_sig", 64'(signature), 64'h0);
        chk("t5_rst_cnt", 64'(sample_count), 64'h0);
        y_valid = 0;
        step();
        rst_n = 1;
        step(); step();
        chk("t5_no_done", 64'(ndone), 64'(nd0));

        // abort mid-window
        begin_win(16'd5);
        for (int i = 0; i < 2; i++) begin
            y_in = rand_y(); y_valid = 1; step();
        end
        abort = 1; y_valid = 1;
        step();
        abort = 0; y_valid = 0;
        chk("t6_busy", 64'(busy), 64'h0);
        chk("t6_cnt", 64'(sample_count), 64'h2);
        step(); step();
        chk("t6_no_done", 64'(ndone), 64'(nd0));

        // 21 random vectors with random gaps
        for (int i = 0; i < 21; i++) vec[i] = rand_y();
        expected_sig = sig_of(21);
        begin_win(16'd21);
        begin
            int k = 0;
            while (k < 21) begin
                y_valid = ($urandom_range(0, 3) != 0);
                y_in = y_valid ? vec[k] : rand_y();
                if (y_valid) k++;
                step();
            end
        end
        y_valid = 0;
        chk("t7_sig", 64'(signature), 64'(sig_of(21)));
        step();
        chk("t7_match", 64'(match), 64'h1);

        // random soak
        for (int c = 0; c < 600; c++) begin
            start = ($urandom_range(0, 3) == 0);
            abort = ($urandom_range(0, 24) == 0);
            num_cycles = 16'($urandom_range(0, 5));
            y_valid = ($urandom_range(0, 9) < 7);
            y_in = rand_y();
            expected_sig = $urandom_range(0, 1) != 0 ? m_sig : $urandom;
            step();
        end
        idle_in();
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
